// File: rtl/uart_receiver.sv
// uart_receiver: UART receive engine (start, 8 data LSB-first, optional parity, stop)
// with valid/ready output handshake and parity/framing/overrun status.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx,
   input  logic       i_ready,
   output logic [7:0] o_data_out,
   output logic       o_valid,
   output logic       o_parity_error,
   output logic       o_framing_error,
   output logic       o_overrun,
   output logic       o_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        r_state;
   logic          r_rx1, r_rx2, r_rx3;
   logic          r_brk, r_par;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          w_fall, w_half, w_full;

   assign w_fall = r_rx3 & ~r_rx2;
   assign w_half = r_cnt == HALF_M1;
   assign w_full = r_cnt == FULL_M1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= IDLE;
         r_rx1           <= 1'b1;
         r_rx2           <= 1'b1;
         r_rx3           <= 1'b1;
         r_brk           <= 1'b0;
         r_par           <= 1'b0;
         r_cnt           <= '0;
         r_bit           <= '0;
         r_shift         <= '0;
         o_data_out      <= '0;
         o_valid         <= 1'b0;
         o_parity_error  <= 1'b0;
         o_framing_error <= 1'b0;
         o_overrun       <= 1'b0;
         o_busy          <= 1'b0;
      end else begin
         r_rx1 <= i_rx;
         r_rx2 <= r_rx1;
         r_rx3 <= r_rx2;
         if (o_valid && i_ready) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               r_bit <= '0;
               // after a break the line must return high before a new edge counts
               if (r_brk) r_brk <= ~r_rx2;
               else if (w_fall) begin
                  r_state <= START;
                  o_busy  <= 1'b1;
               end
            end
            START: begin
               r_cnt <= w_half ? '0 : r_cnt + CW'(1);
               if (w_half) begin
                  r_state <= r_rx2 ? IDLE : DATA;
                  o_busy  <= ~r_rx2;
               end
            end
            DATA: begin
               r_cnt <= w_full ? '0 : r_cnt + CW'(1);
               if (w_full) begin
                  r_shift <= {r_rx2, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) r_state <= (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
            PARITY: begin
               r_cnt <= w_full ? '0 : r_cnt + CW'(1);
               if (w_full) begin
                  r_par   <= r_rx2;
                  r_state <= STOP;
               end
            end
            STOP: begin
               r_cnt <= w_full ? '0 : r_cnt + CW'(1);
               // return to IDLE at the stop sample so back-to-back frames are caught
               if (w_full) begin
                  r_state         <= IDLE;
                  o_busy          <= 1'b0;
                  r_brk           <= ~r_rx2;
                  o_data_out      <= r_shift;
                  o_parity_error  <= (PARITY_EN != 0) && (r_par != (^r_shift ^ 1'(PARITY_ODD)));
                  o_framing_error <= ~r_rx2;
                  o_valid         <= 1'b1;
                  o_overrun       <= o_valid & ~i_ready;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed scenarios plus randomized frames checked against
// a held-frame reference model of the receiver's user-visible behaviour.
module tb_uart_receiver;
   localparam int N    = 16;
   localparam int H    = N / 2;
   localparam int PEN  = 1;
   localparam int PODD = 0;
   localparam int LAT  = 3 + H + (PEN != 0 ? 10 : 9) * N;

   logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, ready = 1'b0;
   logic [7:0] data_out;
   logic       valid, parity_error, framing_error, overrun, busy;

   uart_receiver #(.CLKS_PER_BIT(N), .PARITY_EN(PEN), .PARITY_ODD(PODD)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_ready(ready),
      .o_data_out(data_out), .o_valid(valid), .o_parity_error(parity_error),
      .o_framing_error(framing_error), .o_overrun(overrun), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [7:0] m_data = '0;
   logic m_valid = 0, m_pe = 0, m_fe = 0, m_ovr = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return ^d ^ 1'(PODD);
   endfunction

   task automatic send(input logic [7:0] d, input logic par, input logic stop);
      rx = 1'b0;
      tick(N);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(N);
      end
      if (PEN != 0) begin
         rx = par;
         tick(N);
      end
      rx = stop;
      tick(N);
   endtask

   function automatic void model_frame(input logic [7:0] d, input logic par, input logic stop, input logic rdy);
      m_ovr   = m_valid & ~rdy;
      m_valid = 1'b1;
      m_data  = d;
      m_pe    = (PEN != 0) && (par != good_par(d));
      m_fe    = ~stop;
   endfunction

   task automatic accept();
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic check_out(input string tag);
      check({tag, ".valid"}, valid, m_valid);
      check({tag, ".overrun"}, overrun, m_ovr);
      if (m_valid) begin
         check({tag, ".data"}, data_out, m_data);
         check({tag, ".parity_error"}, parity_error, m_pe);
         check({tag, ".framing_error"}, framing_error, m_fe);
      end
   endtask

   task automatic send_chk(input string tag, input logic [7:0] d, input logic par, input logic stop);
      send(d, par, stop);
      model_frame(d, par, stop, 1'b0);
      check_out(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic seen;
      logic [7:0] d;
      logic p, s;
      tick(3);
      check("rst.data", data_out, 8'h00);
      check("rst.valid", valid, 0);
      check("rst.parity_error", parity_error, 0);
      check("rst.framing_error", framing_error, 0);
      check("rst.overrun", overrun, 0);
      check("rst.busy", busy, 0);
      rst_n = 1'b1;
      tick(3);

      // clean frame with latency measurement
      fork
         send(8'hA5, 1'b0, 1'b1);
         begin
            n = 0;
            while (!valid && n < 400) begin
               tick(1);
               n++;
            end
            check("clean.latency", n, LAT);
         end
      join
      model_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      check_out("clean");
      accept();
      check("clean.valid_after_accept", valid, 0);
      check_out("clean.acc");

      // parity error, then break with stop bit 0
      send_chk("perr", 8'h3C, 1'b1, 1'b1);
      accept();
      send_chk("ferr", 8'h81, good_par(8'h81), 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 3 * N; i++) begin
         tick(1);
         seen |= busy;
      end
      check("ferr.no_restart", seen, 0);
      rx = 1'b1;
      tick(4);
      accept();

      // glitch rejection
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         seen |= busy;
      end
      check("glitch.busy_pulse", seen, 1);
      check("glitch.busy_end", busy, 0);
      check("glitch.valid", valid, 0);
      send_chk("glitch.next", 8'h5A, good_par(8'h5A), 1'b1);
      accept();

      // overrun with back-to-back frames
      send_chk("ovr.first", 8'h11, good_par(8'h11), 1'b1);
      send_chk("ovr.second", 8'h22, good_par(8'h22), 1'b1);
      accept();
      check_out("ovr.acc");

      // ready asserted exactly on the completion cycle of the second frame
      send_chk("sim.first", 8'h11, good_par(8'h11), 1'b1);
      fork
         send(8'h22, good_par(8'h22), 1'b1);
         begin
            tick(LAT - 1);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
         end
      join
      model_frame(8'h22, good_par(8'h22), 1'b1, 1'b1);
      check_out("sim");
      accept();

      // reset during data bit 4 while an earlier frame is still held
      send_chk("mid.held", 8'h33, good_par(8'h33), 1'b1);
      rx = 1'b0;
      tick(N);
      rx = 1'b1;
      tick(4 * N + 8);
      check("mid.busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid.data", data_out, 8'h00);
      check("mid.valid", valid, 0);
      check("mid.flags", {parity_error, framing_error, overrun}, 3'b000);
      check("mid.busy", busy, 0);
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      send_chk("mid.after", 8'h42, good_par(8'h42), 1'b1);
      accept();

      // randomized frames with random errors, gaps and acceptance
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
         s = ($urandom_range(0, 4) != 0);
         send_chk($sformatf("rand%0d", i), d, p, s);
         rx = 1'b1;
         tick($urandom_range(2, 10));
         if ($urandom_range(0, 1) == 1) accept();
      end
      check_out("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
